// File: rtl/halftone_pkg.sv
// Shared constants and helpers for the halftone error-diffusion stage.
package halftone_pkg;

  // Signed widths: per-pixel quantisation error and x16-scaled accumulators
  localparam int ERR_W = 9;
  localparam int ACC_W = 13;

  // Floyd-Steinberg weights (sixteenths): right, below-left, below, below-right
  localparam int W_R  = 7;
  localparam int W_BL = 3;
  localparam int W_B  = 5;
  localparam int W_BR = 1;

  typedef enum logic {
    MODE_THRESH  = 1'b0,
    MODE_DIFFUSE = 1'b1
  } mode_e;

  // Clamp a signed corrected pixel value into the 0..255 range
  function automatic logic [7:0] sat_u8(input logic signed [ACC_W:0] v);
    logic [7:0] r;
    if (v[ACC_W]) begin
      r = 8'd0;
    end else if (|v[ACC_W-1:8]) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/halftone_line_buf.sv
// One row of next-row error accumulators: combinational read, registered write.
module halftone_line_buf
  import halftone_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = ACC_W
) (
  input  logic                 clk,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data
);

  logic signed [DW-1:0] mem [DEPTH];

  assign rd_data = mem[rd_addr];

  // Contents are always written before being read with first_row clear, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/halftone_error_diffuser.sv
// Gray-to-1-bit halftoning stage: fixed threshold or Floyd-Steinberg diffusion,
// one pixel per clock with valid/ready on both sides and a registered result.
module halftone_error_diffuser
  import halftone_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [7:0] threshold,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_gray,
  input  logic       in_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_eol,
  output logic       out_eof
);

  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  localparam logic signed [ACC_W-1:0] K_R  = ACC_W'(W_R);
  localparam logic signed [ACC_W-1:0] K_BL = ACC_W'(W_BL);
  localparam logic signed [ACC_W-1:0] K_B  = ACC_W'(W_B);
  localparam logic signed [ACC_W-1:0] K_BR = ACC_W'(W_BR);

  // Architectural state
  logic [AW-1:0]            x;
  logic [YW-1:0]            y;
  logic                     first_row;
  logic signed [ERR_W-1:0]  e_left;
  logic signed [ACC_W-1:0]  ca;
  logic signed [ACC_W-1:0]  cb;
  logic                     pend_wr;
  logic signed [ACC_W-1:0]  pend_data;

  // Per-pixel datapath
  logic                     accept;
  logic                     diffuse;
  logic [AW-1:0]            px;
  logic [YW-1:0]            py;
  logic                     fr;
  logic                     row_end;
  logic signed [ERR_W-1:0]  el_eff;
  logic signed [ERR_W-1:0]  el_hold;
  logic signed [ACC_W-1:0]  ca_eff;
  logic signed [ACC_W-1:0]  cb_eff;
  logic signed [ACC_W-1:0]  el_ext;
  logic signed [ACC_W-1:0]  lb_rd;
  logic signed [ACC_W-1:0]  lb_term;
  logic signed [ACC_W-1:0]  e_cur;
  logic signed [ACC_W-1:0]  e_shift;
  logic signed [ACC_W:0]    sum;
  logic [7:0]               c;
  logic                     bit_c;
  logic signed [ERR_W-1:0]  err;
  logic signed [ACC_W-1:0]  err_acc;
  logic signed [ACC_W-1:0]  left_data;
  logic signed [ACC_W-1:0]  cb_next;
  logic signed [ACC_W-1:0]  ca_next;

  // Line buffer write port
  logic                     lb_wr_en;
  logic [AW-1:0]            lb_wr_addr;
  logic signed [ACC_W-1:0]  lb_wr_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign diffuse  = (mode == MODE_DIFFUSE);

  halftone_line_buf #(
    .DEPTH (IMG_W),
    .AW    (AW),
    .DW    (ACC_W)
  ) u_line_buf (
    .clk     (clk),
    .rd_addr (px),
    .rd_data (lb_rd),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_wr_addr),
    .wr_data (lb_wr_data)
  );

  // Effective position and error context; in_sof forces a fresh frame origin
  always_comb begin
    px      = in_sof ? '0 : x;
    py      = in_sof ? '0 : y;
    fr      = in_sof | first_row;
    row_end = (px == X_LAST);
    el_eff  = (in_sof || (px == '0)) ? '0 : e_left;
    el_hold = in_sof ? '0 : e_left;
    ca_eff  = in_sof ? '0 : ca;
    cb_eff  = in_sof ? '0 : cb;
  end

  // Corrected value, binarisation and the error split into next-row terms
  always_comb begin
    el_ext    = ACC_W'(el_eff);
    lb_term   = fr ? '0 : lb_rd;
    e_cur     = (K_R * el_ext) + lb_term;
    e_shift   = e_cur >>> 4;
    sum       = $signed({{(ACC_W - 7){1'b0}}, in_gray}) + {e_shift[ACC_W-1], e_shift};
    c         = diffuse ? sat_u8(sum) : in_gray;
    bit_c     = (c >= threshold);
    err       = $signed(ERR_W'(c)) - (bit_c ? ERR_W'(255) : ERR_W'(0));
    err_acc   = ACC_W'(err);
    left_data = cb_eff + (K_BL * err_acc);
    cb_next   = ca_eff + (K_B * err_acc);
    ca_next   = K_BR * err_acc;
  end

  // Row-end write of lb[IMG_W-1] is deferred one cycle; the pixel accepted then
  // is always at column 0, which never writes, so the port is free
  always_comb begin
    lb_wr_en   = 1'b0;
    lb_wr_addr = '0;
    lb_wr_data = '0;
    if (pend_wr) begin
      lb_wr_en   = 1'b1;
      lb_wr_addr = X_LAST;
      lb_wr_data = pend_data;
    end else if (accept && diffuse && (px != '0)) begin
      lb_wr_en   = 1'b1;
      lb_wr_addr = px - 1'b1;
      lb_wr_data = left_data;
    end
  end

  // Raster counters, first-row flag, carries and the deferred row-end write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      first_row <= 1'b1;
      e_left    <= '0;
      ca        <= '0;
      cb        <= '0;
      pend_wr   <= 1'b0;
      pend_data <= '0;
    end else begin
      pend_wr   <= accept && diffuse && row_end;
      pend_data <= cb_next;
      if (accept) begin
        x         <= row_end ? '0 : px + 1'b1;
        y         <= row_end ? ((py == Y_LAST) ? '0 : py + 1'b1) : py;
        first_row <= (row_end && (py == '0)) ? 1'b0 : fr;
        if (diffuse) begin
          e_left <= row_end ? '0 : err;
          ca     <= row_end ? '0 : ca_next;
          cb     <= row_end ? '0 : cb_next;
        end else begin
          e_left <= el_hold;
          ca     <= ca_eff;
          cb     <= cb_eff;
        end
      end
    end
  end

  // Output register: load on accept, drop valid once consumed, hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bit   <= bit_c;
      out_eol   <= row_end;
      out_eof   <= row_end && (py == Y_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_halftone_error_diffuser.sv
// Self-checking bench for halftone_error_diffuser against a classic
// Floyd-Steinberg next-row error plane model.
module tb_halftone_error_diffuser;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] threshold = 8'd128;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_gray = 8'd0;
  logic       in_sof = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_bit;
  logic       out_eol;
  logic       out_eof;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  halftone_error_diffuser #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .threshold (threshold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  // Reference model: current-row error plane, next-row error plane, right error
  int m_x, m_y, m_err_right;
  bit m_first;
  int m_cur [W];
  int m_nxt [W];

  task automatic model_reset();
    m_x = 0; m_y = 0; m_first = 1'b1; m_err_right = 0;
    for (int i = 0; i < W; i++) begin
      m_cur[i] = 0;
      m_nxt[i] = 0;
    end
  endtask

  task automatic model_step(input int gray, input bit sof, input bit md, input int thr,
                            output bit b, output bit eol, output bit eof);
    int e_cur, c, e;
    if (sof) begin
      m_x = 0; m_y = 0; m_first = 1'b1; m_err_right = 0;
      for (int i = 0; i < W; i++) m_nxt[i] = 0;
    end
    if (md) begin
      e_cur = m_err_right + (m_first ? 0 : m_cur[m_x]);
      c = gray + (e_cur >>> 4);
      if (c < 0) c = 0;
      if (c > 255) c = 255;
    end else begin
      c = gray;
    end
    b = (c >= thr);
    e = c - (b ? 255 : 0);
    if (md) begin
      m_err_right = (m_x == W - 1) ? 0 : 7 * e;
      if (m_x > 0) m_nxt[m_x - 1] += 3 * e;
      m_nxt[m_x] += 5 * e;
      if (m_x < W - 1) m_nxt[m_x + 1] += e;
    end
    eol = (m_x == W - 1);
    eof = eol && (m_y == H - 1);
    if (eol) begin
      for (int i = 0; i < W; i++) begin
        m_cur[i] = m_nxt[i];
        m_nxt[i] = 0;
      end
      if (m_y == 0) m_first = 1'b0;
      m_x = 0;
      m_y = (m_y == H - 1) ? 0 : m_y + 1;
    end else begin
      m_x++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present one pixel for a single cycle; acc reports whether in_ready was high
  task automatic send_pixel(input logic [7:0] gray, input logic [7:0] thr, input logic sof,
                            output logic acc);
    in_valid = 1'b1; in_gray = gray; threshold = thr; in_sof = sof;
    #1 acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_bit, out_eol, out_eof} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v/b/eol/eof=%b required 0000",
               {out_valid, out_bit, out_eol, out_eof});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_threshold();
    logic [7:0] grays [4] = '{8'd127, 8'd128, 8'd0, 8'd255};
    bit hand [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic acc;
    logic [7:0] g;
    bit eb, el, ef;
    do_reset();
    mode = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      g = (i < 4) ? grays[i] : 8'($urandom_range(0, 255));
      send_pixel(g, 8'd128, 1'b0, acc);
      model_step(int'(g), 1'b0, 1'b0, 128, eb, el, ef);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("[TB] FAIL thr_accept%0d: got in_ready=%b required 1", i, acc);
      end
      if (i < 4) begin
        checks++;
        if ({out_valid, out_bit, out_eol, out_eof} !== {1'b1, hand[i], (i == 3), 1'b0}) begin
          errors++;
          $display("[TB] FAIL thr_hand%0d: got v/b/eol/eof=%b required %b", i,
                   {out_valid, out_bit, out_eol, out_eof}, {1'b1, hand[i], (i == 3), 1'b0});
        end
      end
      checks++;
      if ({out_valid, out_bit, out_eol, out_eof} !== {1'b1, eb, (i % W == W - 1), (i == 2 * W - 1)}) begin
        errors++;
        $display("[TB] FAIL thr_px%0d: got v/b/eol/eof=%b required %b", i,
                 {out_valid, out_bit, out_eol, out_eof}, {1'b1, eb, (i % W == W - 1), (i == 2 * W - 1)});
      end
    end
  endtask

  task automatic test_ed_row();
    bit hand [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic acc;
    bit eb, el, ef;
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < W * H; i++) begin
      send_pixel(8'd128, 8'd128, 1'b0, acc);
      model_step(128, 1'b0, 1'b1, 128, eb, el, ef);
      if (i < 5) begin
        checks++;
        if (out_bit !== hand[i]) begin
          errors++;
          $display("[TB] FAIL ed_const_hand%0d: got bit=%b required %b", i, out_bit, hand[i]);
        end
      end
      checks++;
      if ({acc, out_valid, out_bit, out_eol, out_eof} !== {2'b11, eb, el, ef}) begin
        errors++;
        $display("[TB] FAIL ed_const_px%0d: got acc/v/b/eol/eof=%b required %b", i,
                 {acc, out_valid, out_bit, out_eol, out_eof}, {2'b11, eb, el, ef});
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] grays [4] = '{8'd100, 8'd255, 8'd200, 8'd0};
    logic [7:0] thrs  [4] = '{8'd200, 8'd255, 8'd100, 8'd100};
    bit hand [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic acc;
    logic [7:0] g, t;
    bit eb, el, ef;
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      g = (i < 4) ? grays[i] : 8'($urandom_range(0, 255));
      t = (i < 4) ? thrs[i] : 8'd128;
      send_pixel(g, t, 1'b0, acc);
      model_step(int'(g), 1'b0, 1'b1, int'(t), eb, el, ef);
      if (i < 4) begin
        checks++;
        if (out_bit !== hand[i]) begin
          errors++;
          $display("[TB] FAIL sat_hand%0d: got bit=%b required %b", i, out_bit, hand[i]);
        end
      end
      checks++;
      if ({acc, out_valid, out_bit, out_eol, out_eof} !== {2'b11, eb, el, ef}) begin
        errors++;
        $display("[TB] FAIL sat_px%0d: got acc/v/b/eol/eof=%b required %b", i,
                 {acc, out_valid, out_bit, out_eol, out_eof}, {2'b11, eb, el, ef});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] g [8];
    logic [7:0] t [8];
    logic acc;
    bit eb, el, ef, hb, hl, hf;
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      g[i] = 8'($urandom_range(0, 255));
      t[i] = 8'($urandom_range(1, 255));
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        out_ready = 1'b0; in_valid = 1'b1; in_gray = g[i]; threshold = t[i]; in_sof = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready_low%0d: got %b required 0", k, in_ready);
          end
          @(posedge clk);
          #1;
          checks++;
          if ({out_valid, out_bit, out_eol, out_eof} !== {1'b1, hb, hl, hf}) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got v/b/eol/eof=%b required %b", k,
                     {out_valid, out_bit, out_eol, out_eof}, {1'b1, hb, hl, hf});
          end
        end
        out_ready = 1'b1;
        #1 acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end else begin
        send_pixel(g[i], t[i], 1'b0, acc);
      end
      model_step(int'(g[i]), 1'b0, 1'b1, int'(t[i]), eb, el, ef);
      hb = eb; hl = el; hf = ef;
      checks++;
      if ({acc, out_valid, out_bit, out_eol, out_eof} !== {2'b11, eb, el, ef}) begin
        errors++;
        $display("[TB] FAIL bp_px%0d: got acc/v/b/eol/eof=%b required %b", i,
                 {acc, out_valid, out_bit, out_eol, out_eof}, {2'b11, eb, el, ef});
      end
    end
  endtask

  task automatic test_resync();
    logic acc;
    logic [7:0] g;
    bit eb, el, ef, sof;
    do_reset();
    mode = 1'b1;
    // 6 pixels reach (2,1); the 7th carries in_sof, then one full frame follows
    for (int i = 0; i < 6 + W * H; i++) begin
      g = 8'($urandom_range(0, 255));
      sof = (i == 6);
      send_pixel(g, 8'd128, sof, acc);
      model_step(int'(g), sof, 1'b1, 128, eb, el, ef);
      if (i >= 6) begin
        checks++;
        if ({out_eol, out_eof} !== {((i - 6) % W == W - 1), (i - 6 == W * H - 1)}) begin
          errors++;
          $display("[TB] FAIL resync_flags%0d: got eol/eof=%b required %b", i - 6,
                   {out_eol, out_eof}, {((i - 6) % W == W - 1), (i - 6 == W * H - 1)});
        end
      end
      checks++;
      if ({acc, out_valid, out_bit, out_eol, out_eof} !== {2'b11, eb, el, ef}) begin
        errors++;
        $display("[TB] FAIL resync_px%0d: got acc/v/b/eol/eof=%b required %b", i,
                 {acc, out_valid, out_bit, out_eol, out_eof}, {2'b11, eb, el, ef});
      end
    end
  endtask

  task automatic test_reset_midrow();
    logic acc;
    logic [7:0] g;
    bit eb, el, ef;
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      g = 8'($urandom_range(0, 255));
      send_pixel(g, 8'd128, 1'b0, acc);
    end
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrow_reset_valid: got %b required 0", out_valid);
    end
    model_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < W; i++) begin
      g = 8'($urandom_range(0, 255));
      send_pixel(g, 8'd128, 1'b0, acc);
      model_step(int'(g), 1'b0, 1'b1, 128, eb, el, ef);
      checks++;
      if ({acc, out_valid, out_bit, out_eol, out_eof} !== {2'b11, eb, (i == W - 1), 1'b0}) begin
        errors++;
        $display("[TB] FAIL midrow_px%0d: got acc/v/b/eol/eof=%b required %b", i,
                 {acc, out_valid, out_bit, out_eol, out_eof}, {2'b11, eb, (i == W - 1), 1'b0});
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    logic [7:0] g, t;
    bit eb, el, ef;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      mode = (pass == 0);
      for (int i = 0; i < 3 * W * H; i++) begin
        g = 8'($urandom_range(0, 255));
        t = 8'($urandom_range(0, 255));
        send_pixel(g, t, 1'b0, acc);
        model_step(int'(g), 1'b0, mode, int'(t), eb, el, ef);
        checks++;
        if ({acc, out_valid, out_bit, out_eol, out_eof} !== {2'b11, eb, el, ef}) begin
          errors++;
          $display("[TB] FAIL rand_m%0d_px%0d: got acc/v/b/eol/eof=%b required %b", mode, i,
                   {acc, out_valid, out_bit, out_eol, out_eof}, {2'b11, eb, el, ef});
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
          checks++;
          if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_idle%0d: got out_valid=%b required 0", i, out_valid);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_ed_row();
    test_saturation();
    test_backpressure();
    test_resync();
    test_reset_midrow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
